// File: rtl/tc_multi.sv
// Multi-channel down-counting timer with a shared write-1-to-clear pending register and combined irq.
// Optional TC_PWM_EN adds MODE 2 auto-reload with a per-channel square wave on pwm_o.
module tc_multi #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [7:2]      add_i,
  input  logic [31:0]     dat_i,
  output logic [31:0]     dat_o,
  output logic            irq,
  output logic [N_CH-1:0] pwm_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StCnt} state_e;

  localparam logic [1:0]       RegCtrl   = 2'd0;
  localparam logic [1:0]       RegPreset = 2'd1;
  localparam logic [1:0]       RegStatus = 2'd3;
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  logic [3:0] chan;
  logic [1:0] sel;
  assign chan = add_i[7:4];
  assign sel  = add_i[3:2];

  logic [3:0]       ctrl_q    [N_CH];
  logic [3:0]       ctrl_d    [N_CH];
  logic [CNT_W-1:0] preset_q  [N_CH];
  logic [CNT_W-1:0] preset_d  [N_CH];
  logic [CNT_W-1:0] count_q   [N_CH];
  logic [CNT_W-1:0] count_d   [N_CH];
  state_e           state_q   [N_CH];
  state_e           state_d   [N_CH];
  logic [N_CH-1:0]  pending_q, pending_d, pending_set, status_clr, wr_sel, reload;
`ifdef TC_PWM_EN
  logic [N_CH-1:0]  pwm_q, pwm_d;
`endif

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      wr_sel[i] = we_i && (sel != RegStatus) && (int'(chan) == i);
`ifdef TC_PWM_EN
      reload[i] = (ctrl_q[i][2:1] == 2'd1) || (ctrl_q[i][2:1] == 2'd2);
`else
      reload[i] = (ctrl_q[i][2:1] == 2'd1);
`endif
    end
    status_clr = (we_i && sel == RegStatus) ? dat_i[N_CH-1:0] : '0;
  end

  always_comb begin
    pending_set = '0;
`ifdef TC_PWM_EN
    pwm_d = pwm_q;
`endif
    for (int i = 0; i < N_CH; i++) begin
      ctrl_d[i]   = ctrl_q[i];
      preset_d[i] = preset_q[i];
      count_d[i]  = count_q[i];
      state_d[i]  = state_q[i];
      unique case (state_q[i])
        StIdle: if (ctrl_q[i][0]) state_d[i] = StLoad;
        StLoad: begin
          if (!ctrl_q[i][0]) begin
            state_d[i] = StIdle;
          end else begin
            count_d[i] = preset_q[i];
            state_d[i] = StCnt;
`ifdef TC_PWM_EN
            if (ctrl_q[i][2:1] == 2'd2) pwm_d[i] = ~pwm_q[i];
`endif
            // A zero preset is a terminal event on the load itself.
            if (preset_q[i] == '0) begin
              pending_set[i] = 1'b1;
              if (!reload[i]) begin
                ctrl_d[i][0] = 1'b0;
                state_d[i]   = StIdle;
              end
            end
          end
        end
        StCnt: begin
          if (!ctrl_q[i][0]) begin
            state_d[i] = StIdle;
          end else if (count_q[i] == '0) begin
            state_d[i] = StLoad;
          end else begin
            count_d[i] = count_q[i] - CntOne;
            if (count_q[i] == CntOne) begin
              pending_set[i] = 1'b1;
              if (reload[i]) begin
                state_d[i] = StLoad;
              end else begin
                ctrl_d[i][0] = 1'b0;
                state_d[i]   = StIdle;
              end
            end
          end
        end
        default: state_d[i] = StIdle;
      endcase
      // Bus writes override the terminal-event EN clear on the same edge.
      if (wr_sel[i]) begin
        if (sel == RegCtrl)   ctrl_d[i]   = dat_i[3:0];
        if (sel == RegPreset) preset_d[i] = dat_i[CNT_W-1:0];
      end
`ifdef TC_PWM_EN
      if (!ctrl_q[i][0]) pwm_d[i] = 1'b0;
`endif
    end
    pending_d = (pending_q & ~status_clr) | pending_set;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q    <= '{default: '0};
      preset_q  <= '{default: '0};
      count_q   <= '{default: '0};
      state_q   <= '{default: StIdle};
      pending_q <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

`ifdef TC_PWM_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) pwm_q <= '0;
    else       pwm_q <= pwm_d;
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) pwm_o[i] = pwm_q[i] & ctrl_q[i][0];
  end
`else
  assign pwm_o = '0;
`endif

  always_comb begin
    irq   = 1'b0;
    dat_o = '0;
    for (int i = 0; i < N_CH; i++) begin
      irq = irq | (pending_q[i] & ctrl_q[i][3]);
      if (int'(chan) == i) begin
        unique case (sel)
          2'd0:    dat_o[3:0]       = ctrl_q[i];
          2'd1:    dat_o[CNT_W-1:0] = preset_q[i];
          2'd2:    dat_o[CNT_W-1:0] = count_q[i];
          default: dat_o            = '0;
        endcase
      end
    end
    if (sel == RegStatus) dat_o = 32'(pending_q);
  end

endmodule

// File: tb/tb_tc_multi.sv
// Directed bench for tc_multi: hand-computed expectations; stimulus driven and sampled on negedge.
module tb_tc_multi;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        we_i  = 1'b0;
  logic [7:2]  add_i = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        irq;
  logic [3:0]  pwm_o;

  int n_checks = 0;
  int n_pass   = 0;

  tc_multi #(.N_CH(4), .CNT_W(32)) u_dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we_i  (we_i),
    .add_i (add_i),
    .dat_i (dat_i),
    .dat_o (dat_o),
    .irq   (irq),
    .pwm_o (pwm_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:2] addr(input int ch, input int r);
    logic [3:0] c;
    logic [1:0] s;
    c = 4'(ch);
    s = 2'(r);
    return {c, s};
  endfunction

  task automatic tick();
    @(negedge clk_i);
  endtask

  // Called at a negedge; the write lands on the next posedge.
  task automatic wr(input int ch, input int r, input logic [31:0] d);
    we_i  = 1'b1;
    add_i = addr(ch, r);
    dat_i = d;
    @(negedge clk_i);
    we_i  = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input int ch, input int r, input logic [31:0] exp);
    add_i = addr(ch, r);
    #1;
    check(tag, dat_o, exp);
  endtask

  initial begin
    tick();
    tick();
    rst_i = 1'b0;

    // Reset state
    for (int c = 0; c < 4; c++) begin
      chk_reg($sformatf("rst_ctrl%0d", c), c, 0, 32'h0);
      chk_reg($sformatf("rst_preset%0d", c), c, 1, 32'h0);
      chk_reg($sformatf("rst_count%0d", c), c, 2, 32'h0);
    end
    chk_reg("rst_status", 0, 3, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_pwm", 32'(pwm_o), 32'h0);

    // ch1 one-shot (MODE 3 behaves as MODE 0 here), IM set
    wr(1, 1, 32'd3);
    wr(1, 0, 32'hF);
    tick();
    for (int v = 3; v >= 0; v--) begin
      tick();
      chk_reg($sformatf("ch1_count_%0d", v), 1, 2, 32'(v));
      if (v == 1) check("ch1_irq_early", 32'(irq), 32'h0);
    end
    chk_reg("ch1_status", 1, 3, 32'h2);
    check("ch1_irq", 32'(irq), 32'h1);
    chk_reg("ch1_ctrl_en_clr", 1, 0, 32'hE);
    tick();
    chk_reg("ch1_count_hold", 1, 2, 32'h0);
    wr(0, 3, 32'h2);
    check("ch1_irq_clr", 32'(irq), 32'h0);
    chk_reg("ch1_status_clr", 2, 3, 32'h0);

    // Out-of-range channel is inert and does not alias
    wr(5, 1, 32'h77);
    chk_reg("oor_preset", 5, 1, 32'h0);
    chk_reg("oor_no_alias", 1, 1, 32'h3);

    // ch2 auto-reload, IM clear
    wr(2, 1, 32'd2);
    wr(2, 0, 32'h3);
    tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_reg($sformatf("ch2_seq%0d", k), 2, 2, 32'(2 - (k % 3)));
      if (k % 3 == 2) begin
        chk_reg($sformatf("ch2_status%0d", k), 2, 3, 32'h4);
        check($sformatf("ch2_irq_masked%0d", k), 32'(irq), 32'h0);
      end
    end
    check("ch2_pwm_zero", 32'(pwm_o), 32'h0);
    wr(2, 0, 32'hB);
    check("ch2_irq_unmask", 32'(irq), 32'h1);
    wr(2, 0, 32'h0);
    tick();
    wr(0, 3, 32'hF);
    chk_reg("ch2_status_clr", 0, 3, 32'h0);

    // ch0 MODE1 and ch3 MODE0, PRESET 1; clear collides with a ch0 terminal event
    wr(0, 1, 32'd1);
    wr(3, 1, 32'd1);
    wr(0, 0, 32'h3);
    wr(3, 0, 32'h1);
    tick();
    tick();
    tick();
    chk_reg("both_status", 0, 3, 32'h9);
    chk_reg("ch0_count_1", 0, 2, 32'h1);
    wr(0, 3, 32'h9);
    chk_reg("set_wins", 0, 3, 32'h1);
    chk_reg("ch3_ctrl_en_clr", 3, 0, 32'h0);
    wr(0, 0, 32'h0);
    tick();
    wr(0, 3, 32'hF);
    chk_reg("status_idle", 0, 3, 32'h0);

    // ch3 PRESET 0 one-shot: pending on the load, EN cleared
    wr(3, 1, 32'd0);
    wr(3, 0, 32'h1);
    tick();
    tick();
    chk_reg("p0_status", 3, 3, 32'h8);
    chk_reg("p0_ctrl", 3, 0, 32'h0);
    wr(0, 3, 32'h8);

    // Mid-count disable, preset change, reload, COUNT write ignored
    wr(0, 1, 32'd10);
    wr(0, 0, 32'h1);
    tick();
    tick();
    chk_reg("mid_load", 0, 2, 32'd10);
    tick();
    tick();
    wr(0, 0, 32'h0);
    tick();
    chk_reg("mid_hold", 0, 2, 32'd7);
    wr(0, 1, 32'd4);
    chk_reg("mid_preset_no_effect", 0, 2, 32'd7);
    wr(0, 0, 32'h1);
    tick();
    tick();
    chk_reg("mid_reload", 0, 2, 32'd4);
    wr(0, 2, 32'h55);
    chk_reg("count_ro", 0, 2, 32'd3);
    wr(0, 0, 32'h0);
    tick();

`ifdef TC_PWM_EN
    wr(0, 1, 32'd2);
    wr(0, 0, 32'h5);
    tick();
    tick();
    check("pwm_first", 32'(pwm_o[0]), 32'h1);
    tick();
    tick();
    tick();
    check("pwm_second", 32'(pwm_o[0]), 32'h0);
    tick();
    tick();
    tick();
    check("pwm_third", 32'(pwm_o[0]), 32'h1);
    wr(0, 0, 32'h0);
    check("pwm_off", 32'(pwm_o[0]), 32'h0);
    tick();
    wr(0, 3, 32'hF);
`else
    check("pwm_tied", 32'(pwm_o), 32'h0);
`endif

    // Reset mid-count
    wr(1, 1, 32'd5);
    wr(1, 0, 32'h9);
    tick();
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk_reg("rst_mid_count", 1, 2, 32'h0);
    chk_reg("rst_mid_ctrl", 1, 0, 32'h0);
    chk_reg("rst_mid_preset", 1, 1, 32'h0);
    tick();
    tick();
    chk_reg("rst_mid_idle", 1, 2, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
